prbs_frame_ctrl: RTL and testbench
==================================

Name: prbs_frame_ctrl

Overview:
- Sequencer for the prbs15 generator in the OFDM baseband source path.
- Reseeds the generator and gates its trig_en so it emits an exact number of bits per OFDM symbol and symbols per frame, with optional idle gaps between symbols.
- Honours downstream backpressure.
- Emits symbol and frame markers aligned to the generator's registered output (dout_valid/prbs_out).

Parameters:
LEN_W, 12, width of bits-per-symbol count
SYM_W, 8, width of symbols-per-frame count and symbol index
GAP_W, 8, width of inter-symbol gap count

Ports:
prbs_clk  in  1  clock, shared with prbs15
prbs_rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle frame start request
abort  in  1  one-cycle frame abort request
cfg_sym_len  in  LEN_W  bits per symbol; sampled on accepted start
cfg_num_sym  in  SYM_W  symbols per frame; sampled on accepted start
cfg_gap  in  GAP_W  idle cycles between symbols (0 allowed); sampled on accepted start
dout_ready  in  1  downstream can take one bit this cycle
gen_rst_n  out  1  synchronous active-low reseed to prbs15 prbs_rst_n
trig_en  out  1  advance request to prbs15
sym_first  out  1  marks the first bit of a symbol, aligned with prbs15 dout_valid
sym_last  out  1  marks the last bit of a symbol, aligned with prbs15 dout_valid
sym_idx  out  SYM_W  index of the symbol currently marked (0-based)
frame_done  out  1  one-cycle pulse, frame completed
busy  out  1  high in every state except IDLE
cfg_err  out  1  one-cycle pulse, start rejected

Behaviour:
- Reset values (asynchronous, prbs_rst_n low):
  - state=IDLE; all counters 0.
  - gen_rst_n=1, trig_en=0, sym_first=0, sym_last=0, sym_idx=0, frame_done=0, busy=0, cfg_err=0.
- States: IDLE, RESEED, RUN, GAP, DONE.
- IDLE:
  - start with cfg_sym_len!=0 and cfg_num_sym!=0: latch all cfg values, go to RESEED next cycle.
  - start with either value 0: pulse cfg_err the next cycle, stay IDLE.
- RESEED: gen_rst_n=0 for exactly one cycle (prbs15 reloads 15'h7fff), then RUN. bit_cnt=0, sym_cnt=0.
- RUN:
  - trig_en = dout_ready AND NOT abort. This is combinational from the registered state.
  - Each cycle with trig_en high increments bit_cnt.
  - bit_cnt==len-1 with trig_en, and sym_cnt==num-1: go to DONE.
  - Otherwise at symbol end: sym_cnt+1, bit_cnt=0, then go to GAP if gap!=0, else stay in RUN (back-to-back symbols, no bubble).
  - dout_ready low: hold all counters, trig_en=0.
- GAP: trig_en=0; count gap cycles, then RUN. Gap time is independent of dout_ready.
- DONE: frame_done=1 for one cycle, then IDLE. frame_done coincides with the cycle in which the last bit's sym_last is presented.
- Markers:
  - sym_first_pre = trig_en & (bit_cnt==0).
  - sym_last_pre = trig_en & (bit_cnt==len-1).
  - Both, and sym_idx, are registered one cycle so they line up with prbs15 dout_valid/prbs_out (one-cycle generator latency).
  - len==1: sym_first and sym_last are both high on the same bit.
- Counting:
  - Counters compare against latched len-1 and num-1.
  - No wrap occurs: the maximum of each counter equals its configured value minus 1.
- start while busy: ignored, no cfg_err.
- abort (any non-IDLE state):
  - trig_en forced 0 that same cycle.
  - Next cycle: IDLE, marker pipeline cleared, no frame_done.
  - gen_rst_n stays 1.
- abort in IDLE: no effect.
- start and abort in the same cycle in IDLE: abort has no effect, start is processed.
- Reset mid-frame: immediate return to reset values. prbs15 is reseeded by its own reset or by the next RESEED.

Optional Feature:
- Macro: PRBS_RESEED_PER_SYM_EN.
- Defined: RESEED (gen_rst_n low one cycle) is inserted before every symbol, after GAP if any. Every symbol therefore starts with the same sequence, and each symbol adds one cycle.
- Undefined: reseed only once per frame; the sequence runs continuously across symbols.

Test Plan:
- Basic frame: len=4, num=2, gap=0, dout_ready=1.
  - gen_rst_n low 1 cycle, then trig_en high 8 consecutive cycles.
  - sym_first on bits 0 and 4, sym_last on bits 3 and 7, sym_idx 0 then 1.
  - frame_done once; first 4 prbs_out bits 1,1,1,1 after seed 7fff.
- Gap: len=3, num=3, gap=2 → trig_en pattern 111 00 111 00 111; busy high throughout; frame_done after 3rd symbol.
- Backpressure: len=5, num=1, dout_ready toggling 1,0,1,0,...
  - Exactly 5 trig_en cycles.
  - sym_last on the 5th valid bit only.
- Config error: start with cfg_num_sym=0 → cfg_err one cycle, busy stays 0, no trig_en.
- Abort: len=16, num=4, abort during symbol 1 bit 7.
  - trig_en 0 that cycle, IDLE next, no frame_done.
  - A new start then reseeds and outputs 1,1,1,1.
- Macro on: len=4, num=2, gap=0 → two RESEED pulses; both symbols output identical 4-bit sequences.

Source files
------------

// File: rtl/prbs_frame_ctrl.sv
// prbs_frame_ctrl: reseeds and gates prbs15 into fixed-length symbols/frames.
// Build option PRBS_RESEED_PER_SYM_EN reseeds the generator before every symbol.
module prbs_frame_ctrl #(
   parameter int LEN_W = 12,
   parameter int SYM_W = 8,
   parameter int GAP_W = 8
) (
   input  logic             prbs_clk,
   input  logic             prbs_rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic [LEN_W-1:0] cfg_sym_len,
   input  logic [SYM_W-1:0] cfg_num_sym,
   input  logic [GAP_W-1:0] cfg_gap,
   input  logic             dout_ready,
   output logic             gen_rst_n,
   output logic             trig_en,
   output logic             sym_first,
   output logic             sym_last,
   output logic [SYM_W-1:0] sym_idx,
   output logic             frame_done,
   output logic             busy,
   output logic             cfg_err
);

`ifdef PRBS_RESEED_PER_SYM_EN
   localparam logic PER_SYM = 1'b1;
`else
   localparam logic PER_SYM = 1'b0;
`endif

   typedef enum logic [2:0] {
      S_IDLE,
      S_RESEED,
      S_RUN,
      S_GAP,
      S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] bit_cnt_q, bit_cnt_d;
   logic [SYM_W-1:0] num_q, num_d;
   logic [SYM_W-1:0] sym_cnt_q, sym_cnt_d;
   logic [SYM_W-1:0] sym_idx_q, sym_idx_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
   logic             sym_first_q, sym_first_d;
   logic             sym_last_q, sym_last_d;
   logic             cfg_err_q, cfg_err_d;
   logic             trig, reseed_n, done;
   logic             bit_end, sym_end, gap_end, cfg_ok;

   assign bit_end = (bit_cnt_q == len_q - LEN_W'(1));
   assign sym_end = (sym_cnt_q == num_q - SYM_W'(1));
   assign gap_end = (gap_cnt_q == gap_q - GAP_W'(1));
   assign cfg_ok  = (cfg_sym_len != '0) && (cfg_num_sym != '0);

   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      num_d       = num_q;
      gap_d       = gap_q;
      bit_cnt_d   = bit_cnt_q;
      sym_cnt_d   = sym_cnt_q;
      gap_cnt_d   = gap_cnt_q;
      sym_idx_d   = sym_idx_q;
      sym_first_d = 1'b0;
      sym_last_d  = 1'b0;
      cfg_err_d   = 1'b0;
      trig        = 1'b0;
      reseed_n    = 1'b1;
      done        = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               if (cfg_ok) begin
                  len_d     = cfg_sym_len;
                  num_d     = cfg_num_sym;
                  gap_d     = cfg_gap;
                  bit_cnt_d = '0;
                  sym_cnt_d = '0;
                  gap_cnt_d = '0;
                  sym_idx_d = '0;
                  state_d   = S_RESEED;
               end else begin
                  cfg_err_d = 1'b1;
               end
            end
         end
         S_RESEED: begin
            if (abort) begin
               state_d   = S_IDLE;
               sym_idx_d = '0;
            end else begin
               reseed_n = 1'b0;
               state_d  = S_RUN;
            end
         end
         S_RUN: begin
            trig = dout_ready & ~abort;
            if (abort) begin
               state_d   = S_IDLE;
               sym_idx_d = '0;
            end else if (trig) begin
               // markers ride one cycle behind to meet the generator output
               sym_first_d = (bit_cnt_q == '0);
               sym_last_d  = bit_end;
               sym_idx_d   = sym_cnt_q;
               bit_cnt_d   = bit_cnt_q + LEN_W'(1);
               if (bit_end) begin
                  bit_cnt_d = '0;
                  if (sym_end) begin
                     state_d = S_DONE;
                  end else begin
                     sym_cnt_d = sym_cnt_q + SYM_W'(1);
                     gap_cnt_d = '0;
                     if (gap_q != '0) begin
                        state_d = S_GAP;
                     end else if (PER_SYM) begin
                        state_d = S_RESEED;
                     end
                  end
               end
            end
         end
         S_GAP: begin
            if (abort) begin
               state_d   = S_IDLE;
               sym_idx_d = '0;
            end else begin
               gap_cnt_d = gap_cnt_q + GAP_W'(1);
               if (gap_end) begin
                  state_d = PER_SYM ? S_RESEED : S_RUN;
               end
            end
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
            if (abort) begin
               sym_idx_d = '0;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge prbs_clk or negedge prbs_rst_n) begin
      if (!prbs_rst_n) begin
         state_q     <= S_IDLE;
         len_q       <= '0;
         num_q       <= '0;
         gap_q       <= '0;
         bit_cnt_q   <= '0;
         sym_cnt_q   <= '0;
         gap_cnt_q   <= '0;
         sym_idx_q   <= '0;
         sym_first_q <= 1'b0;
         sym_last_q  <= 1'b0;
         cfg_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         num_q       <= num_d;
         gap_q       <= gap_d;
         bit_cnt_q   <= bit_cnt_d;
         sym_cnt_q   <= sym_cnt_d;
         gap_cnt_q   <= gap_cnt_d;
         sym_idx_q   <= sym_idx_d;
         sym_first_q <= sym_first_d;
         sym_last_q  <= sym_last_d;
         cfg_err_q   <= cfg_err_d;
      end
   end

   assign gen_rst_n  = reseed_n;
   assign trig_en    = trig;
   assign sym_first  = sym_first_q;
   assign sym_last   = sym_last_q;
   assign sym_idx    = sym_idx_q;
   assign frame_done = done;
   assign busy       = (state_q != S_IDLE);
   assign cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_prbs_frame_ctrl.sv
// tb_prbs_frame_ctrl: randomized frames against a schedule-queue model,
// plus directed reset, gap, backpressure, config-error and abort scenarios.
module tb_prbs_frame_ctrl;

   localparam int LMAX = 16384;
`ifdef PRBS_RESEED_PER_SYM_EN
   localparam int RPS = 1;
`else
   localparam int RPS = 0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [11:0] cfg_sym_len = '0;
   logic [7:0]  cfg_num_sym = '0;
   logic [7:0]  cfg_gap = '0;
   logic        dout_ready = 1'b0;
   logic        gen_rst_n, trig_en, sym_first, sym_last;
   logic [7:0]  sym_idx;
   logic        frame_done, busy, cfg_err;

   int checks = 0;
   int errors = 0;
   int mode = 0;
   int cyc = 0;

   always #5 clk = ~clk;

   prbs_frame_ctrl dut (
      .prbs_clk   (clk),
      .prbs_rst_n (rst_n),
      .start      (start),
      .abort      (abort),
      .cfg_sym_len(cfg_sym_len),
      .cfg_num_sym(cfg_num_sym),
      .cfg_gap    (cfg_gap),
      .dout_ready (dout_ready),
      .gen_rst_n  (gen_rst_n),
      .trig_en    (trig_en),
      .sym_first  (sym_first),
      .sym_last   (sym_last),
      .sym_idx    (sym_idx),
      .frame_done (frame_done),
      .busy       (busy),
      .cfg_err    (cfg_err)
   );

   // stand-in prbs15: seed 7fff, emits msb, one-cycle latency
   logic [14:0] lfsr;
   logic        prbs_out, prbs_valid;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr <= 15'h7fff;
         prbs_out <= 1'b0;
         prbs_valid <= 1'b0;
      end else if (!gen_rst_n) begin
         lfsr <= 15'h7fff;
         prbs_out <= 1'b0;
         prbs_valid <= 1'b0;
      end else begin
         prbs_valid <= trig_en;
         if (trig_en) begin
            prbs_out <= lfsr[14];
            lfsr <= {lfsr[13:0], lfsr[14] ^ lfsr[13]};
         end
      end
   end

   logic       l_trig [LMAX];
   logic       l_rdy  [LMAX];
   logic       l_grst [LMAX];
   logic       l_first[LMAX];
   logic       l_last [LMAX];
   logic [7:0] l_idx  [LMAX];
   logic       l_done [LMAX];
   logic       l_busy [LMAX];
   logic       l_err  [LMAX];
   logic       l_bit  [LMAX];
   logic       l_val  [LMAX];
   bit         ref_bits[4096];

   always @(negedge clk) begin
      if (cyc < LMAX) begin
         l_trig[cyc]  = trig_en;
         l_rdy[cyc]   = dout_ready;
         l_grst[cyc]  = gen_rst_n;
         l_first[cyc] = sym_first;
         l_last[cyc]  = sym_last;
         l_idx[cyc]   = sym_idx;
         l_done[cyc]  = frame_done;
         l_busy[cyc]  = busy;
         l_err[cyc]   = cfg_err;
         l_bit[cyc]   = prbs_out;
         l_val[cyc]   = prbs_valid;
      end
      cyc++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
      case (mode)
         0: dout_ready = 1'b1;
         1: dout_ready = ~dout_ready;
         default: dout_ready = ($urandom_range(0, 3) != 0);
      endcase
      #1;
   endtask

   task automatic wait_idle(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         tick();
         if (!busy) begin
            ok = 1'b1;
            return;
         end
      end
   endtask

   task automatic launch(input int len, input int num,
                         input int gap, output int base);
      tick();
      base = cyc;
      cfg_sym_len = 12'(len);
      cfg_num_sym = 8'(num);
      cfg_gap = 8'(gap);
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic test_reset();
      tick();
      tick();
      checks++;
      if ({gen_rst_n, trig_en, sym_first, sym_last,
           frame_done, busy, cfg_err} !== 7'b1000000) begin
         errors++;
         $display("FAIL reset_outs got=%b want=1000000",
                  {gen_rst_n, trig_en, sym_first, sym_last,
                   frame_done, busy, cfg_err});
      end
      checks++;
      if (sym_idx !== 8'd0) begin
         errors++;
         $display("FAIL reset_idx got=%0d want=0", sym_idx);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      int base, rp, k;
      bit ok;
      logic [5:0] got, want;
      mode = 0;
      tick();
      base = cyc;
      cfg_sym_len = 12'd4;
      cfg_num_sym = 8'd2;
      cfg_gap = 8'd0;
      start = 1'b1;
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      wait_idle(ok);
      tick();
      tick();
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL basic_timeout busy=%b want 0", busy);
      end
      for (int r = 0; r <= 11 + RPS; r++) begin
         rp = r - 1;
         k = -1;
         if (rp >= 2 && rp <= 5) k = rp - 2;
         if (rp >= 6 + RPS && rp <= 9 + RPS) k = rp - 6 - RPS + 4;
         want[5] = (r >= 2 && r <= 5) || (r >= 6 + RPS && r <= 9 + RPS);
         want[4] = !(r == 1 || (RPS == 1 && r == 6));
         want[3] = (r == 10 + RPS);
         want[2] = (r >= 1 && r <= 10 + RPS);
         want[1] = (k >= 0) && (k % 4 == 0);
         want[0] = (k >= 0) && (k % 4 == 3);
         got = {l_trig[base+r], l_grst[base+r], l_done[base+r],
                l_busy[base+r], l_first[base+r], l_last[base+r]};
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL basic_cyc r=%0d got=%b want=%b", r, got, want);
         end
         if (k >= 0) begin
            checks++;
            if (l_idx[base+r] !== 8'(k / 4)) begin
               errors++;
               $display("FAIL basic_idx r=%0d got=%0d want=%0d",
                        r, l_idx[base+r], k / 4);
            end
         end
      end
      checks++;
      if ({l_bit[base+3], l_bit[base+4], l_bit[base+5], l_bit[base+6]}
          !== 4'b1111) begin
         errors++;
         $display("FAIL basic_bits got=%b%b%b%b want=1111",
                  l_bit[base+3], l_bit[base+4],
                  l_bit[base+5], l_bit[base+6]);
      end
   endtask

   task automatic test_gap();
      int base, plen;
      bit ok;
      logic [14:0] pat;
      mode = 0;
      plen = (RPS == 1) ? 15 : 13;
      pat = (RPS == 1) ? 15'b111000111000111 : 15'b001110011100111;
      launch(3, 3, 2, base);
      wait_idle(ok);
      tick();
      tick();
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL gap_timeout busy=%b want 0", busy);
      end
      for (int r = 0; r < plen; r++) begin
         checks++;
         if (l_trig[base+2+r] !== pat[plen-1-r]) begin
            errors++;
            $display("FAIL gap_trig r=%0d got=%b want=%b",
                     r, l_trig[base+2+r], pat[plen-1-r]);
         end
      end
      for (int r = 1; r <= plen + 2; r++) begin
         checks++;
         if (l_busy[base+r] !== 1'b1) begin
            errors++;
            $display("FAIL gap_busy r=%0d got=%b want=1",
                     r, l_busy[base+r]);
         end
      end
      checks++;
      if ({l_done[base+plen+1], l_done[base+plen+2], l_busy[base+plen+3]}
          !== 3'b010) begin
         errors++;
         $display("FAIL gap_done got=%b want=010",
                  {l_done[base+plen+1], l_done[base+plen+2],
                   l_busy[base+plen+3]});
      end
   endtask

   task automatic test_backpressure();
      int base, ntrig, nlast, nbad, t5, tlast, tdone;
      bit ok;
      mode = 1;
      launch(5, 1, 0, base);
      wait_idle(ok);
      tick();
      tick();
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL bp_timeout busy=%b want 0", busy);
      end
      ntrig = 0;
      nlast = 0;
      nbad = 0;
      t5 = -1;
      tlast = -2;
      tdone = -3;
      for (int t = base; t < cyc; t++) begin
         if (l_trig[t]) begin
            ntrig++;
            if (ntrig == 5) t5 = t;
         end
         if (l_trig[t] && !l_rdy[t]) nbad++;
         if (l_last[t]) begin
            nlast++;
            tlast = t;
         end
         if (l_done[t]) tdone = t;
      end
      checks++;
      if (ntrig !== 5) begin
         errors++;
         $display("FAIL bp_trig_count got=%0d want=5", ntrig);
      end
      checks++;
      if (nbad !== 0) begin
         errors++;
         $display("FAIL bp_trig_not_ready got=%0d want=0", nbad);
      end
      checks++;
      if (nlast !== 1 || tlast !== t5 + 1) begin
         errors++;
         $display("FAIL bp_last count=%0d at=%0d want 1 at %0d",
                  nlast, tlast, t5 + 1);
      end
      checks++;
      if (tdone !== t5 + 1) begin
         errors++;
         $display("FAIL bp_done at=%0d want=%0d", tdone, t5 + 1);
      end
   endtask

   task automatic test_cfg_err();
      mode = 0;
      for (int c = 0; c < 2; c++) begin
         tick();
         cfg_sym_len = (c == 0) ? 12'd4 : 12'd0;
         cfg_num_sym = (c == 0) ? 8'd0 : 8'd3;
         start = 1'b1;
         tick();
         start = 1'b0;
         checks++;
         if ({cfg_err, busy, trig_en} !== 3'b100) begin
            errors++;
            $display("FAIL cfg_err_pulse case=%0d got=%b want=100",
                     c, {cfg_err, busy, trig_en});
         end
         tick();
         checks++;
         if ({cfg_err, busy, trig_en} !== 3'b000) begin
            errors++;
            $display("FAIL cfg_err_after case=%0d got=%b want=000",
                     c, {cfg_err, busy, trig_en});
         end
      end
   endtask

   task automatic test_abort();
      int base, n, nd;
      bit ok;
      mode = 0;
      launch(16, 4, 0, base);
      n = 0;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (n == 23) begin
            abort = 1'b1;
            #1;
            ok = 1'b1;
            break;
         end
         if (trig_en) n++;
      end
      checks++;
      if (!ok || {trig_en, gen_rst_n} !== 2'b01) begin
         errors++;
         $display("FAIL abort_cycle reached=%b trig/grst=%b want 1 01",
                  ok, {trig_en, gen_rst_n});
      end
      tick();
      abort = 1'b0;
      #1;
      checks++;
      if ({busy, sym_first, sym_last, frame_done, sym_idx}
          !== 12'd0) begin
         errors++;
         $display("FAIL abort_next got=%b want=0",
                  {busy, sym_first, sym_last, frame_done, sym_idx});
      end
      tick();
      nd = 0;
      for (int t = base; t < cyc; t++) nd += int'(l_done[t]);
      checks++;
      if (nd !== 0) begin
         errors++;
         $display("FAIL abort_no_done got=%0d want=0", nd);
      end
      launch(4, 1, 0, base);
      wait_idle(ok);
      tick();
      tick();
      checks++;
      if ({l_bit[base+3], l_bit[base+4], l_bit[base+5], l_bit[base+6],
           l_val[base+3], l_val[base+6]} !== 6'b111111) begin
         errors++;
         $display("FAIL abort_restart_bits got=%b want=111111",
                  {l_bit[base+3], l_bit[base+4], l_bit[base+5],
                   l_bit[base+6], l_val[base+3], l_val[base+6]});
      end
   endtask

   task automatic test_reset_mid();
      int base;
      mode = 0;
      launch(10, 2, 1, base);
      for (int i = 0; i < 5; i++) tick();
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({gen_rst_n, trig_en, sym_first, sym_last,
           frame_done, busy, cfg_err, sym_idx} !== 15'b100000000000000) begin
         errors++;
         $display("FAIL reset_mid got=%b want=100000000000000",
                  {gen_rst_n, trig_en, sym_first, sym_last,
                   frame_done, busy, cfg_err, sym_idx});
      end
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_random();
      int len, num, gap, base, k, pk, post, item;
      int sched[$];
      bit ok;
      logic pv, e_trig, e_grst, e_done, e_busy, e_first, e_last;
      logic [6:0] got, want;
      for (int it = 0; it < 24; it++) begin
         mode = it % 3;
         len = (it < 3) ? 1 : $urandom_range(1, 9);
         num = $urandom_range(1, 4);
         gap = $urandom_range(0, 3);
         launch(len, num, gap, base);
         cfg_sym_len = 12'($urandom_range(0, 4095));
         cfg_gap = 8'($urandom_range(0, 255));
         ok = 1'b0;
         for (int i = 0; i < 2000; i++) begin
            if (i == 2) begin
               start = 1'b1;
               cfg_num_sym = 8'd0;
            end
            tick();
            start = 1'b0;
            if (!busy) begin
               ok = 1'b1;
               break;
            end
         end
         checks++;
         if (!ok) begin
            errors++;
            $display("FAIL rand_timeout it=%0d busy=%b want 0", it, busy);
         end
         tick();
         tick();
         tick();
         sched.delete();
         sched.push_back(0);
         for (int s = 0; s < num; s++) begin
            for (int b = 0; b < len; b++) sched.push_back(1);
            if (s < num - 1) begin
               for (int g = 0; g < gap; g++) sched.push_back(2);
               if (RPS == 1) sched.push_back(0);
            end
         end
         k = 0;
         pk = 0;
         pv = 1'b0;
         post = 0;
         for (int t = base + 1; post < 3 && t < cyc; t++) begin
            e_trig = 1'b0;
            e_grst = 1'b1;
            e_done = 1'b0;
            e_busy = 1'b1;
            if (sched.size() > 0) begin
               item = sched[0];
               if (item == 0) begin
                  e_grst = 1'b0;
                  void'(sched.pop_front());
               end else if (item == 2) begin
                  void'(sched.pop_front());
               end else if (l_rdy[t]) begin
                  e_trig = 1'b1;
                  void'(sched.pop_front());
               end
            end else begin
               e_done = (post == 0);
               e_busy = (post == 0);
               post++;
            end
            e_first = pv && (pk % len == 0);
            e_last = pv && (pk % len == len - 1);
            want = {e_trig, e_grst, e_done, e_busy, e_first, e_last, 1'b0};
            got = {l_trig[t], l_grst[t], l_done[t], l_busy[t],
                   l_first[t], l_last[t], l_err[t]};
            checks++;
            if (got !== want) begin
               errors++;
               $display("FAIL rand_cyc it=%0d len=%0d num=%0d gap=%0d t=%0d got=%b want=%b",
                        it, len, num, gap, t - base, got, want);
            end
            if (pv) begin
               checks++;
               if ({l_idx[t], l_bit[t], l_val[t]} !==
                   {8'(pk / len),
                    ref_bits[(RPS == 1) ? (pk % len) : pk], 1'b1}) begin
                  errors++;
                  $display("FAIL rand_bit it=%0d k=%0d got=%0d/%b/%b want=%0d/%b/1",
                           it, pk, l_idx[t], l_bit[t], l_val[t], pk / len,
                           ref_bits[(RPS == 1) ? (pk % len) : pk]);
               end
            end
            pv = e_trig;
            if (e_trig) begin
               pk = k;
               k++;
            end
         end
      end
   endtask

   initial begin
      logic [14:0] s;
      s = 15'h7fff;
      for (int k = 0; k < 4096; k++) begin
         ref_bits[k] = s[14];
         s = {s[13:0], s[14] ^ s[13]};
      end
      test_reset();
      test_basic();
      test_gap();
      test_backpressure();
      test_cfg_err();
      test_abort();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
